mcu_core_param: RTL and testbench

- Parametrised successor to the team's fixed 8-bit microprocessor core. Same 8-bit instruction encoding and external instruction-memory hookup: PCoutput drives IMEM, and instruction comes back combinationally.
- Generalised in data width, PC width and data-memory depth.
- Adds single-step mode, halt detection, a retire strobe, and a hex display of the last written value sized to DATA_W.

---
 rtl/mcu_core_param.sv | 145 ++++++++++++++
 tb/tb_mcu_core_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_core_param.sv
// Parametrised 8-bit-encoded microprocessor core: 4 registers, internal data memory,
// single-step control, halt detection, retire strobe and registered hex display.
module mcu_core_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DMEM_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              instruction,
    input  logic                    step_mode,
    input  logic                    step,
    output logic [ADDR_W-1:0]       PCoutput,
    output logic [7*DATA_W/4-1:0]   segDisplay,
    output logic                    halted,
    output logic                    retired
);

    localparam int unsigned MemAw  = $clog2(DMEM_DEPTH);
    localparam int unsigned Digits = DATA_W / 4;

    typedef enum logic [1:0] {OpAdd = 2'b00, OpLw = 2'b01, OpSw = 2'b10, OpJmp = 2'b11} op_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              halted_q, halted_d;
    logic              retired_q;
    logic              step_q;

    op_e               op;
    logic [1:0]        rs, rt, rd;
    logic [5:0]        imm6;
    logic [DATA_W-1:0] rs_val, rt_val, sum, ld_val;
    logic [16:0]       addr_sum;
    logic [MemAw-1:0]  mem_addr;
    logic [31:0]       jmp_off;
    logic              retire;
    logic              rf_we, mem_we;
    logic [1:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;

    assign op       = op_e'(instruction[7:6]);
    assign rs       = instruction[5:4];
    assign rt       = instruction[3:2];
    assign rd       = instruction[1:0];
    assign imm6     = instruction[5:0];
    assign rs_val   = rf_q[rs];
    assign rt_val   = rf_q[rt];
    assign sum      = rs_val + rt_val;
    // rs zero-extended, imm2 sign-extended; only the low address bits survive
    assign addr_sum = 17'(rs_val) + {{15{rd[1]}}, rd};
    assign mem_addr = addr_sum[MemAw-1:0];
    assign ld_val   = dmem_q[mem_addr];
    assign jmp_off  = {{26{imm6[5]}}, imm6};

    // step_q holds last cycle's step so only a rising edge retires in step mode
    assign retire = !halted_q && (!step_mode || (step && !step_q));

    always_comb begin
        pc_d     = pc_q;
        disp_d   = disp_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_wa    = rd;
        rf_wd    = sum;
        mem_we   = 1'b0;
        if (retire) begin
            unique case (op)
                OpAdd: begin
                    rf_we  = 1'b1;
                    disp_d = sum;
                    pc_d   = pc_q + ADDR_W'(1);
                end
                OpLw: begin
                    rf_we  = 1'b1;
                    rf_wa  = rt;
                    rf_wd  = ld_val;
                    disp_d = ld_val;
                    pc_d   = pc_q + ADDR_W'(1);
                end
                OpSw: begin
                    mem_we = 1'b1;
                    disp_d = rt_val;
                    pc_d   = pc_q + ADDR_W'(1);
                end
                OpJmp: begin
                    if (imm6 == 6'h3F) halted_d = 1'b1;
                    else pc_d = pc_q + ADDR_W'(1) + jmp_off[ADDR_W-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            disp_q    <= '0;
            halted_q  <= 1'b0;
            retired_q <= 1'b0;
            step_q    <= 1'b1;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem_q[i] <= DATA_W'(i);
        end else begin
            pc_q      <= pc_d;
            disp_q    <= disp_d;
            halted_q  <= halted_d;
            retired_q <= retire;
            step_q    <= step;
            if (rf_we) rf_q[rf_wa] <= rf_wd;
            if (mem_we) dmem_q[mem_addr] <= rt_val;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    for (genvar g = 0; g < int'(Digits); g++) begin : g_digit
        assign segDisplay[7*g +: 7] = hex7(disp_q[4*g +: 4]);
    end

    assign PCoutput = pc_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mcu_core_param.sv
// Bench for mcu_core_param: directed vector table, hand-written step/reset sequences,
// and random instruction streams checked against an arithmetic reference model.
module tb_mcu_core_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  instruction = 8'h00;
    logic        step_mode = 1'b1;
    logic        step = 1'b1;
    logic [7:0]  PCoutput;
    logic [13:0] segDisplay;
    logic        halted;
    logic        retired;

    int total = 0;
    int bad = 0;

    mcu_core_param #(.DATA_W(8), .ADDR_W(8), .DMEM_DEPTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .step_mode   (step_mode),
        .step        (step),
        .PCoutput    (PCoutput),
        .segDisplay  (segDisplay),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state
    int m_pc;
    int m_r [4];
    int m_mem [32];
    int m_disp;
    bit m_halted, m_ret, m_stepd;

    task automatic model_edge(input logic [7:0] ins, input bit r, input bit sm, input bit st);
        int op, rs, rt, rd, imm2, imm6, addr;
        bit ret;
        if (r) begin
            m_pc = 0; m_disp = 0; m_halted = 0; m_ret = 0; m_stepd = 1;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = i;
            return;
        end
        ret = !m_halted && (!sm || (st && !m_stepd));
        m_stepd = st;
        m_ret = ret;
        if (!ret) return;
        op = int'(ins[7:6]); rs = int'(ins[5:4]); rt = int'(ins[3:2]); rd = int'(ins[1:0]);
        imm2 = (rd >= 2) ? rd - 4 : rd;
        imm6 = int'(ins[5:0]);
        if (imm6 >= 32) imm6 -= 64;
        addr = (((m_r[rs] + imm2) % 32) + 32) % 32;
        case (op)
            0: begin
                m_r[rd] = (m_r[rs] + m_r[rt]) % 256;
                m_disp = m_r[rd];
                m_pc = (m_pc + 1) % 256;
            end
            1: begin
                m_r[rt] = m_mem[addr];
                m_disp = m_r[rt];
                m_pc = (m_pc + 1) % 256;
            end
            2: begin
                m_mem[addr] = m_r[rt];
                m_disp = m_r[rt];
                m_pc = (m_pc + 1) % 256;
            end
            default: begin
                if (imm6 == -1) m_halted = 1;
                else m_pc = (((m_pc + 1 + imm6) % 256) + 256) % 256;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] seg_of(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {font[b[7:4]], font[b[3:0]]};
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".pc"}, 32'(PCoutput), 32'(m_pc));
        check({tag, ".seg"}, 32'(segDisplay), 32'(seg_of(m_disp)));
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
        check({tag, ".retired"}, 32'(retired), 32'(m_ret));
    endtask

    task automatic tick();
        model_edge(instruction, rst, step_mode, step);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ins;
        logic [7:0] pc;
        logic [7:0] disp;
        bit         hlt;
        bit         ret;
    } vec_t;

    vec_t vecs [$];
    int   nret;
    int   mode_cnt;

    initial begin
        // Free-run program from the test plan; expected values worked out by hand
        vecs = '{
            '{8'h45, 8'h01, 8'h01, 0, 1},   // LW r1=dmem[1]
            '{8'h16, 8'h02, 8'h02, 0, 1},   // ADD r2=r1+r1
            '{8'h47, 8'h03, 8'h1F, 0, 1},   // LW r1=dmem[31]
            '{8'h15, 8'h04, 8'h3E, 0, 1},
            '{8'h15, 8'h05, 8'h7C, 0, 1},
            '{8'h15, 8'h06, 8'hF8, 0, 1},
            '{8'h15, 8'h07, 8'hF0, 0, 1},
            '{8'h47, 8'h08, 8'h1F, 0, 1},   // r1 back to 0x1F
            '{8'h84, 8'h09, 8'h1F, 0, 1},   // SW dmem[0]=r1
            '{8'h48, 8'h0A, 8'h1F, 0, 1},   // LW r2=dmem[0]
            '{8'hF9, 8'h04, 8'h1F, 0, 1},   // JMP -7
            '{8'h00, 8'h05, 8'h00, 0, 1},   // ADD r0=r0+r0
            '{8'hC3, 8'h09, 8'h00, 0, 1},   // JMP +3 from 0x05
            '{8'hF4, 8'hFE, 8'h00, 0, 1},   // JMP -12 wraps below zero
            '{8'hC1, 8'h00, 8'h00, 0, 1},   // JMP +1 from 0xFE wraps
            '{8'hFF, 8'h00, 8'h00, 1, 1},   // halt retires
            '{8'h00, 8'h00, 8'h00, 1, 0},
            '{8'h45, 8'h00, 8'h00, 1, 0}
        };

        // Reset with step held high, step mode on
        do_reset();
        check("rst.pc", 32'(PCoutput), 32'h00);
        check("rst.seg", 32'(segDisplay), 32'(14'b1000000_1000000));
        check("rst.halted", 32'(halted), 32'h0);
        check("rst.retired", 32'(retired), 32'h0);
        nret = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nret += int'(retired);
        end
        check("held_step.retires", 32'(nret), 32'h0);
        check("held_step.pc", 32'(PCoutput), 32'h00);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        check("step_after_rst.pc", 32'(PCoutput), 32'h01);
        check("step_after_rst.retired", 32'(retired), 32'h1);
        tick();
        check("step_after_rst.one_pulse", 32'(retired), 32'h0);
        check_model("step_after_rst");

        // Directed table in free-run mode
        step_mode = 1'b0;
        do_reset();
        step = 1'b0;
        foreach (vecs[i]) begin
            instruction = vecs[i].ins;
            tick();
            check($sformatf("vec%0d.pc", i), 32'(PCoutput), 32'(vecs[i].pc));
            check($sformatf("vec%0d.seg", i), 32'(segDisplay), 32'(seg_of(int'(vecs[i].disp))));
            check($sformatf("vec%0d.halted", i), 32'(halted), 32'(vecs[i].hlt));
            check($sformatf("vec%0d.retired", i), 32'(retired), 32'(vecs[i].ret));
        end
        check("table.dmem0", 32'(m_mem[0]), 32'h1F);
        do_reset();
        check("halt_clear.halted", 32'(halted), 32'h0);
        check("halt_clear.pc", 32'(PCoutput), 32'h00);

        // Step mode sequences
        step_mode = 1'b1;
        step = 1'b0;
        instruction = 8'h00;
        nret = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nret += int'(retired);
        end
        check("idle.pc", 32'(PCoutput), 32'h00);
        check("idle.retires", 32'(nret), 32'h0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("pulse.pc", 32'(PCoutput), 32'h01);
        check("pulse.retired", 32'(retired), 32'h1);
        tick();
        check("pulse.after", 32'(retired), 32'h0);
        step = 1'b1;
        nret = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) step = 1'b0;
            tick();
            nret += int'(retired);
        end
        check("hold4.retires", 32'(nret), 32'h1);
        check("hold4.pc", 32'(PCoutput), 32'h02);
        rst = 1'b1;
        step = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_on_step.pc", 32'(PCoutput), 32'h00);
        check("rst_on_step.retired", 32'(retired), 32'h0);
        tick();
        check("rst_on_step.no_fire", 32'(PCoutput), 32'h00);
        check_model("rst_on_step");

        // Random streams against the reference model
        step_mode = 1'b0;
        do_reset();
        step = 1'b0;
        mode_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            instruction = 8'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            step = 1'($urandom);
            if (mode_cnt == 0) begin
                step_mode = 1'($urandom);
                mode_cnt = $urandom_range(5, 60);
            end else begin
                mode_cnt--;
            end
            tick();
            check_model($sformatf("rand%0d", i));
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
